// File: rtl/count_seq_pkg.sv
// Shared types and constants for the display-counter sequencer.
package count_seq_pkg;

    localparam int CW = 4;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_HOLD,
        ST_LOADP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/count_sequencer_tick_divider.sv
// Count-tick generator: one-cycle tick every DIV_COUNT cycles while run is high.
module tick_divider #(
    parameter int DIV_COUNT = 27_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic zero,
    output logic tick
);

    localparam int DW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIV_COUNT - 1);

    logic [DW-1:0] cnt_reg;

    assign tick = run && (cnt_reg == LAST);

    // Outside run the count is frozen so a paused run resumes mid-period.
    always_ff @(posedge clk) begin
        if (reset || zero) begin
            cnt_reg <= '0;
        end else if (run) begin
            cnt_reg <= tick ? '0 : cnt_reg + DW'(1);
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven controller that strobes a 74LS161-style counter from a single
// board clock: run/stop/load/clear, programmable modulus, one-shot or continuous.
module count_sequencer #(
    parameter int DIV_COUNT = 27_000_000,
    parameter int CW        = count_seq_pkg::CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_data,
    input  logic [CW-1:0] modulus,
    input  logic          oneshot,
    input  logic [CW-1:0] ctr_q,
    output logic          ctr_clr_n,
    output logic          ctr_load_n,
    output logic          ctr_en,
    output logic [CW-1:0] ctr_d,
    output logic          running,
    output logic          wrap,
    output logic          done,
    output logic          err
);

    import count_seq_pkg::*;

    state_t        state_reg, state_next, ret_reg, ret_next;
    logic [CW-1:0] m1_reg, m1_next;
    logic          oneshot_reg, oneshot_next;
    logic          clr_n_reg, clr_n_next, load_n_reg, load_n_next, en_reg, en_next;
    logic [CW-1:0] d_reg, d_next;
    logic          rdy_reg, rdy_next;
    logic          wrap_reg, wrap_next, done_reg, done_next, err_reg, err_next;
    logic          tick, accept;
    logic [CW-1:0] live_m1;

    // Terminal count is held as M-1, so modulus 0 wraps naturally to 2^CW-1.
    assign live_m1 = modulus - CW'(1);
    assign accept  = cmd_valid && rdy_reg;

    tick_divider #(.DIV_COUNT(DIV_COUNT)) u_div (
        .clk   (clk),
        .reset (reset),
        .run   (state_reg == ST_RUN),
        .zero  (state_reg == ST_PRIME),
        .tick  (tick)
    );

    always_comb begin
        state_next   = state_reg;
        ret_next     = ret_reg;
        m1_next      = m1_reg;
        oneshot_next = oneshot_reg;
        clr_n_next   = 1'b1;
        load_n_next  = 1'b1;
        en_next      = 1'b0;
        d_next       = '0;
        wrap_next    = 1'b0;
        done_next    = 1'b0;
        err_next     = 1'b0;
        case (state_reg)
            ST_IDLE: if (accept) begin
                case (cmd_op)
                    OP_START: begin
                        state_next   = ST_PRIME;
                        m1_next      = live_m1;
                        oneshot_next = oneshot;
                        clr_n_next   = 1'b0;
                    end
                    OP_LOAD: if (cmd_data > live_m1) begin
                        err_next = 1'b1;
                    end else begin
                        state_next  = ST_LOADP;
                        ret_next    = ST_IDLE;
                        load_n_next = 1'b0;
                        d_next      = cmd_data;
                    end
                    OP_CLEAR: clr_n_next = 1'b0;
                    default:  err_next   = 1'b1;
                endcase
            end
            ST_PRIME: state_next = ST_RUN;
            ST_RUN: begin
                if (tick) begin
                    if (ctr_q == m1_reg) begin
                        clr_n_next = 1'b0;
                        wrap_next  = 1'b1;
                        if (oneshot_reg) begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        en_next = 1'b1;
                    end
                end
                if (accept) begin
                    case (cmd_op)
                        // A one-shot completing on this tick takes precedence over the pause.
                        OP_STOP: if (state_next != ST_DONE) state_next = ST_HOLD;
                        OP_CLEAR: begin
                            state_next = ST_IDLE;
                            clr_n_next = 1'b0;
                            en_next    = 1'b0;
                            wrap_next  = 1'b0;
                            done_next  = 1'b0;
                        end
                        default: err_next = 1'b1;
                    endcase
                end
            end
            ST_HOLD: if (accept) begin
                case (cmd_op)
                    OP_START: state_next = ST_RUN;
                    OP_LOAD: if (cmd_data > m1_reg) begin
                        err_next = 1'b1;
                    end else begin
                        state_next  = ST_LOADP;
                        ret_next    = ST_HOLD;
                        load_n_next = 1'b0;
                        d_next      = cmd_data;
                    end
                    OP_CLEAR: begin
                        state_next = ST_IDLE;
                        clr_n_next = 1'b0;
                    end
                    default: err_next = 1'b1;
                endcase
            end
            ST_LOADP: state_next = ret_reg;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        rdy_next = (state_next == ST_IDLE) || (state_next == ST_RUN) || (state_next == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            ret_reg     <= ST_IDLE;
            m1_reg      <= '0;
            oneshot_reg <= 1'b0;
            clr_n_reg   <= 1'b0;
            load_n_reg  <= 1'b1;
            en_reg      <= 1'b0;
            d_reg       <= '0;
            rdy_reg     <= 1'b0;
            wrap_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ret_reg     <= ret_next;
            m1_reg      <= m1_next;
            oneshot_reg <= oneshot_next;
            clr_n_reg   <= clr_n_next;
            load_n_reg  <= load_n_next;
            en_reg      <= en_next;
            d_reg       <= d_next;
            rdy_reg     <= rdy_next;
            wrap_reg    <= wrap_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    assign cmd_ready  = rdy_reg;
    assign ctr_clr_n  = clr_n_reg;
    assign ctr_load_n = load_n_reg;
    assign ctr_en     = en_reg;
    assign ctr_d      = d_reg;
    assign running    = (state_reg == ST_RUN);
    assign wrap       = wrap_reg;
    assign done       = done_reg;
    assign err        = err_reg;

endmodule
